// File: rtl/alu_op_sequencer.sv
// Sequencer that owns the shared combinational ALU: single-pass ops, shift-add MUL and
// repeated self-add SHL behind a valid/ready request/response handshake.
module alu_op_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_op,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] rsp_result,
  output logic               rsp_err,
  output logic [2:0]         alu_op,
  output logic [WIDTH-1:0]   alu_x,
  output logic [WIDTH-1:0]   alu_y,
  input  logic [WIDTH-1:0]   alu_res,
  input  logic               alu_cout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpMul = 3'b101;
  localparam logic [2:0] OpShl = 3'b110;
  localparam logic [2:0] OpRsv = 3'b111;

  localparam logic [CW-1:0] CntOne  = 1;
  localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StExec, StMulStep, StShlStep, StResp} state_e;

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   acc_q, acc_d;  // MUL high half, or SHL running value
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               err_q, err_d;
  logic               cout_bit;

  assign req_ready  = (state_q == StIdle);
  assign rsp_valid  = (state_q == StResp);
  assign rsp_result = result_q;
  assign rsp_err    = err_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;
    cout_bit = 1'b0;
    alu_op   = OpAdd;
    alu_x    = '0;
    alu_y    = '0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d  = req_op;
          a_d   = req_a;
          b_d   = req_b;
          acc_d = (req_op == OpShl) ? req_a : '0;
          lo_d  = req_b;
          cnt_d = '0;
          case (req_op)
            OpMul: state_d = StMulStep;
            OpShl: begin
              if (req_b[CW-1:0] != '0) begin
                state_d = StShlStep;
              end else begin
                state_d  = StResp;
                result_d = {{WIDTH{1'b0}}, req_a};
                err_d    = 1'b0;
              end
            end
            // Reserved opcode answers immediately without touching the ALU.
            OpRsv: begin
              state_d  = StResp;
              result_d = '0;
              err_d    = 1'b1;
            end
            default: state_d = StExec;
          endcase
        end
      end
      StExec: begin
        alu_op   = op_q;
        alu_x    = a_q;
        alu_y    = b_q;
        cout_bit = ((op_q == OpAdd) || (op_q == OpSub)) ? alu_cout : 1'b0;
        result_d = {{(WIDTH-1){1'b0}}, cout_bit, alu_res};
        err_d    = 1'b0;
        state_d  = StResp;
      end
      StMulStep: begin
        alu_x = acc_q;
        alu_y = lo_q[0] ? a_q : '0;
        // {hi,lo} <= {cout, sum, lo} >> 1
        acc_d = {alu_cout, alu_res[WIDTH-1:1]};
        lo_d  = {alu_res[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + CntOne;
        if (cnt_q == CntLast) begin
          cnt_d    = '0;
          state_d  = StResp;
          result_d = {acc_d, lo_d};
          err_d    = 1'b0;
        end
      end
      StShlStep: begin
        alu_x = acc_q;
        alu_y = acc_q;
        acc_d = alu_res;
        cnt_d = cnt_q + CntOne;
        if ((cnt_q + CntOne) == b_q[CW-1:0]) begin
          cnt_d    = '0;
          state_d  = StResp;
          result_d = {{(WIDTH-1){1'b0}}, alu_cout, alu_res};
          err_d    = 1'b0;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural ALU attached to its ALU port.
module tb_alu_op_sequencer;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           req_valid;
  logic           req_ready;
  logic [2:0]     req_op;
  logic [W-1:0]   req_a;
  logic [W-1:0]   req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [2*W-1:0] rsp_result;
  logic           rsp_err;
  logic [2:0]     alu_op;
  logic [W-1:0]   alu_x;
  logic [W-1:0]   alu_y;
  logic [W-1:0]   alu_res;
  logic           alu_cout;

  int n_checks = 0;
  int n_fail   = 0;
  logic [16:0] exp_q[$];  // {err, result}

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_result(rsp_result),
    .rsp_err   (rsp_err),
    .alu_op    (alu_op),
    .alu_x     (alu_x),
    .alu_y     (alu_y),
    .alu_res   (alu_res),
    .alu_cout  (alu_cout)
  );

  // Logic ops return cout=1 so a sequencer that forwards it would be caught.
  always_comb begin
    {alu_cout, alu_res} = 9'h000;
    case (alu_op)
      3'b000:  {alu_cout, alu_res} = {1'b0, alu_x} + {1'b0, alu_y};
      3'b001:  {alu_cout, alu_res} = {1'b0, alu_x} - {1'b0, alu_y};
      3'b010:  {alu_cout, alu_res} = {1'b1, alu_x & alu_y};
      3'b011:  {alu_cout, alu_res} = {1'b1, alu_x | alu_y};
      3'b100:  {alu_cout, alu_res} = {1'b1, alu_x ^ alu_y};
      default: {alu_cout, alu_res} = 9'h1FF;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] model(input logic [2:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    logic [15:0] r;
    logic        e;
    e = 1'b0;
    case (op)
      3'd0:    r = {8'h00, a} + {8'h00, b};
      3'd1:    r = ({8'h00, a} - {8'h00, b}) & 16'h01FF;
      3'd2:    r = {8'h00, a & b};
      3'd3:    r = {8'h00, a | b};
      3'd4:    r = {8'h00, a ^ b};
      3'd5:    r = {8'h00, a} * {8'h00, b};
      3'd6:    r = ({8'h00, a} << b[2:0]) & 16'h01FF;
      default: begin r = 16'h0000; e = 1'b1; end
    endcase
    return {e, r};
  endfunction

  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int guard;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    guard     = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) check("req_ready_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    // Scramble inputs after the accept edge; the DUT must have latched them.
    req_valid = 1'b0;
    req_op    = 3'($urandom);
    req_a     = 8'($urandom);
    req_b     = 8'($urandom);
    exp_q.push_back(model(op, a, b));
  endtask

  task automatic get(input string tag, input int exp_lat, input logic [2:0] op,
                     input logic [7:0] a, input logic [7:0] b);
    int          lat;
    logic [16:0] e;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!rsp_valid && op == 3'd5 && lat <= W) begin
        check({tag, "_mul_aluy"}, 32'(alu_y), b[lat-1] ? 32'(a) : 32'd0);
        check({tag, "_mul_aluop"}, 32'(alu_op), 32'd0);
      end
    end while (!rsp_valid && lat < 60);
    check({tag, "_latency"}, lat, exp_lat);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h1FFFF;
    check({tag, "_result"}, 32'(rsp_result), 32'(e[15:0]));
    check({tag, "_err"}, 32'(rsp_err), 32'(e[16]));
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check({tag, "_idle_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_idle_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_idle_alu"}, {13'd0, alu_op, alu_x, alu_y}, 32'd0);
  endtask

  initial begin
    logic        saw_valid;
    logic [16:0] e;
    int          guard;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = 3'd0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ready", {31'd0, req_ready}, 32'd1);
    check("reset_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_result", 32'(rsp_result), 32'd0);
    check("reset_err", {31'd0, rsp_err}, 32'd0);
    check("reset_alu", {13'd0, alu_op, alu_x, alu_y}, 32'd0);

    send(3'd0, 8'hFF, 8'h01);  get("add_ff_01", 2, 3'd0, 8'hFF, 8'h01);
    send(3'd1, 8'h10, 8'h20);  get("sub_borrow", 2, 3'd1, 8'h10, 8'h20);
    send(3'd2, 8'hF0, 8'h3C);  get("and", 2, 3'd2, 8'hF0, 8'h3C);
    send(3'd3, 8'hF0, 8'h0C);  get("or", 2, 3'd3, 8'hF0, 8'h0C);
    send(3'd5, 8'd13, 8'd11);  get("mul_13_11", W + 1, 3'd5, 8'd13, 8'd11);
    send(3'd5, 8'hFF, 8'hFF);  get("mul_ff_ff", W + 1, 3'd5, 8'hFF, 8'hFF);
    send(3'd6, 8'h81, 8'd1);   get("shl_81_1", 2, 3'd6, 8'h81, 8'd1);
    send(3'd6, 8'h5A, 8'd0);   get("shl_5a_0", 1, 3'd6, 8'h5A, 8'd0);
    send(3'd6, 8'h03, 8'd7);   get("shl_03_7", 8, 3'd6, 8'h03, 8'd7);
    send(3'd7, 8'h12, 8'h34);  get("reserved", 1, 3'd7, 8'h12, 8'h34);

    // Backpressure: hold the XOR response for 5 cycles while a busy request is offered.
    send(3'd4, 8'hF0, 8'h3C);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!rsp_valid && guard < 60);
    check("bp_latency", guard, 2);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h1FFFF;
    req_valid = 1'b1;
    req_op    = 3'd0;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_result", 32'(rsp_result), 32'(e[15:0]));
      check("bp_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    check("bp_ready_at_release", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_ready_after", {31'd0, req_ready}, 32'd1);
    check("bp_valid_after", {31'd0, rsp_valid}, 32'd0);

    // Reset in the middle of a MUL aborts it.
    send(3'd5, 8'd13, 8'd11);
    void'(exp_q.pop_back());
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_ready", {31'd0, req_ready}, 32'd1);
    check("abort_valid", {31'd0, rsp_valid}, 32'd0);
    check("abort_result", 32'(rsp_result), 32'd0);
    check("abort_err", {31'd0, rsp_err}, 32'd0);
    check("abort_alu", {13'd0, alu_op, alu_x, alu_y}, 32'd0);
    saw_valid = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (rsp_valid) saw_valid = 1'b1;
    end
    check("abort_no_rsp", {31'd0, saw_valid}, 32'd0);
    send(3'd0, 8'd2, 8'd3);    get("add_after_abort", 2, 3'd0, 8'd2, 8'd3);

    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Controller that owns the shared combinational ALU and sequences single- and multi-cycle operations on it behind a valid/ready request/response interface.
- Single-pass ops (ADD/SUB/AND/OR/XOR) take one ALU cycle.
- MUL (shift-add) and SHL (repeated self-add) are built by iterating the ALU's ADD.
- Sits between the register/operand logic and the ALU; it is the only block that drives the ALU inputs.

Parameters:
WIDTH, 8, operand width; result is 2*WIDTH bits; shift count is b[$clog2(WIDTH)-1:0].

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  sequencer can accept (high only in IDLE)
req_op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL, 110 SHL, 111 reserved
req_a  input  WIDTH  operand A
req_b  input  WIDTH  operand B / shift count
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_result  output  2*WIDTH  result
rsp_err  output  1  reserved opcode flag
alu_op  output  3  to ALU, encoding 000..100 as req_op
alu_x  output  WIDTH  ALU operand X
alu_y  output  WIDTH  ALU operand Y
alu_res  input  WIDTH  ALU result (combinational)
alu_cout  input  1  ALU carry out

Behaviour:
- Reset (synchronous, rst high at a rising edge): state IDLE, req_ready=1 in the following cycle, rsp_valid=0, rsp_result=0, rsp_err=0, step counter=0. In IDLE the ALU is driven with alu_op=000, alu_x=0, alu_y=0.
- Reset mid-operation or mid-response aborts the operation; no response is ever produced for it.
- Accept: an edge with req_valid && req_ready. req_op, req_a and req_b are latched at that edge; later input changes are ignored.
- States: IDLE, EXEC, MUL_STEP, SHL_STEP, RESP.
- Transitions from IDLE on accept:
  - op 000..100 -> EXEC
  - op 101 -> MUL_STEP
  - op 110 with count n != 0 -> SHL_STEP
  - op 110 with n = 0 -> RESP, result={0,a}, err=0
  - op 111 -> RESP, result=0, err=1; the ALU is not used
- EXEC: drive alu_op=op, alu_x=a, alu_y=b for one cycle. Next edge captures the result and enters RESP.
  - rsp_result = {0..., cout_bit, alu_res}.
  - cout_bit = alu_cout for ADD/SUB, 0 for logic ops.
- MUL_STEP (unsigned, exactly WIDTH cycles, counter 0..WIDTH-1):
  - Registers hi (WIDTH, init 0) and lo (init b).
  - Each cycle drives alu_op=ADD, alu_x=hi, alu_y = lo[0] ? a : 0.
  - Each edge updates {hi,lo} <= {alu_cout, alu_res, lo} >> 1.
  - After the WIDTH-th step -> RESP with result={hi,lo}.
- SHL_STEP (n cycles):
  - Register r, init a.
  - Each cycle drives alu_op=ADD, alu_x=r, alu_y=r; each edge r <= alu_res.
  - After the n-th step -> RESP with result[WIDTH-1:0]=r, result[WIDTH]=alu_cout of the final step, upper bits 0.
- Latency in edges from the accept edge to RESP entry: EXEC 1, MUL WIDTH, SHL n, SHL n=0 and reserved 0. rsp_valid is high in the cycle after RESP entry.
- RESP: rsp_valid=1; rsp_result and rsp_err are held stable until rsp_valid && rsp_ready at an edge, then -> IDLE. The ALU is driven as in IDLE.
- No same-cycle response-accept and new-request overlap: req_ready rises the cycle after the response is taken.
- rsp_result and rsp_err keep their last values in IDLE; they are meaningful only while rsp_valid=1.
- req_valid while busy is simply not accepted; no error.

Test Plan:
- ADD a=0xFF, b=0x01: rsp_result=0x0100, err=0. rsp_valid appears 2 cycles after the accept cycle.
- MUL a=13, b=11: rsp_result=0x008F after 8 MUL_STEP cycles.
- MUL a=0xFF, b=0xFF: rsp_result=0xFE01. A model ALU in the bench checks alu_y alternates correctly.
- SHL a=0x81, b=1: rsp_result=0x0102.
- SHL a=0x5A, b=0: immediate rsp_result=0x005A with no ALU step.
- Reserved op 111: rsp_err=1, rsp_result=0.
- Backpressure: hold rsp_ready=0 for 5 cycles after XOR a=0xF0, b=0x3C. rsp_valid stays 1 and rsp_result stays 0x00CC; req_ready stays 0 throughout and rises 1 cycle after rsp_ready is asserted.
- Assert rst for 1 cycle during MUL step 4: no rsp_valid ever appears for that request. The next cycle shows req_ready=1 and all outputs at reset values, and a following ADD 2+3 returns 0x0005.
